// File: rtl/jt89_wr_arb.sv
// Two-master write arbiter for the JT89 PSG register port: per-master FIFOs, round-robin
// issue with PSG busy spacing, tone latch/data pairs kept together. Option: JT89_ARB_STATS_EN.
module jt89_wr_arb #(
  parameter int unsigned AW       = 2,
  parameter int unsigned BUSY_CYC = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       a_wr,
  input  logic [7:0] a_din,
  output logic       a_full,
  input  logic       b_wr,
  input  logic [7:0] b_din,
  output logic       b_full,
  output logic       psg_wr_n,
  output logic [7:0] psg_din,
  output logic       busy
`ifdef JT89_ARB_STATS_EN
  ,
  output logic [7:0] a_drops,
  output logic [7:0] b_drops
`endif
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned CW    = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            rr_q, rr_d;
  logic            lock_q, lock_d;
  logic            lock_own_q, lock_own_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            psg_wr_n_q;
  logic [7:0]      psg_din_q;
  logic            busy_q;

  logic [1:0]      wr_c;
  logic [7:0]      din_c [2];
  logic [7:0]      mem_q [2][DEPTH];
  logic [PW-1:0]   wptr_q [2];
  logic [PW-1:0]   wptr_d [2];
  logic [PW-1:0]   rptr_q [2];
  logic [PW-1:0]   rptr_d [2];
  logic [1:0]      full_q, full_d, empty_c, pop_c, push_c;
  logic [7:0]      head_c [2];
  logic [7:0]      issue_byte_c;
  logic            tone_latch_c;

  assign wr_c     = {b_wr, a_wr};
  assign din_c[0] = a_din;
  assign din_c[1] = b_din;

  // FIFO bookkeeping; a push into a full FIFO is taken only when the same cycle pops it
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      empty_c[m] = (wptr_q[m] == rptr_q[m]);
      head_c[m]  = mem_q[m][rptr_q[m][AW-1:0]];
      pop_c[m]   = (state_q == S_ISSUE) && (grant_q == 1'(m));
      push_c[m]  = wr_c[m] && (!full_q[m] || pop_c[m]);
      wptr_d[m]  = wptr_q[m] + PW'(push_c[m]);
      rptr_d[m]  = rptr_q[m] + PW'(pop_c[m]);
      full_d[m]  = (PW'(wptr_d[m] - rptr_d[m]) == PW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (push_c[m]) mem_q[m][wptr_q[m][AW-1:0]] <= din_c[m];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        wptr_q[m] <= '0;
        rptr_q[m] <= '0;
      end
      full_q <= '0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        wptr_q[m] <= wptr_d[m];
        rptr_q[m] <= rptr_d[m];
      end
      full_q <= full_d;
    end
  end

  assign a_full = full_q[0];
  assign b_full = full_q[1];

  // Tone/frequency latch on channels 0-2 must be followed by its data byte from the same master
  assign issue_byte_c = head_c[grant_q];
  assign tone_latch_c = issue_byte_c[7] && !issue_byte_c[4] && (issue_byte_c[6:5] != 2'b11);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (lock_q) begin
          if (!empty_c[lock_own_q]) begin
            grant_d = lock_own_q;
            state_d = S_ISSUE;
          end
        end else if (!empty_c[rr_q]) begin
          grant_d = rr_q;
          state_d = S_ISSUE;
        end else if (!empty_c[~rr_q]) begin
          grant_d = ~rr_q;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d      = CW'(BUSY_CYC);
        rr_d       = ~grant_q;
        lock_d     = tone_latch_c;
        lock_own_d = grant_q;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (clk_en) begin
          cnt_d = cnt_q - CW'(1);
          if ((cnt_q == CW'(1)) || (cnt_q == CW'(0))) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= 1'b0;
      rr_q       <= 1'b0;
      lock_q     <= 1'b0;
      lock_own_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      cnt_q      <= cnt_d;
    end
  end

  // PSG-facing outputs follow the FSM by one register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      psg_wr_n_q <= 1'b1;
      psg_din_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      psg_wr_n_q <= (state_q != S_ISSUE);
      busy_q     <= (state_q != S_IDLE);
      if (state_q == S_ISSUE) psg_din_q <= issue_byte_c;
    end
  end

  assign psg_wr_n = psg_wr_n_q;
  assign psg_din  = psg_din_q;
  assign busy     = busy_q;

`ifdef JT89_ARB_STATS_EN
  logic [7:0] drops_q [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      drops_q[0] <= 8'h00;
      drops_q[1] <= 8'h00;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (wr_c[m] && full_q[m] && !pop_c[m] && (drops_q[m] != 8'hFF))
          drops_q[m] <= drops_q[m] + 8'd1;
      end
    end
  end

  assign a_drops = drops_q[0];
  assign b_drops = drops_q[1];
`endif

endmodule

// File: tb/tb_jt89_wr_arb.sv
// Bench for jt89_wr_arb: directed scenarios plus randomized traffic against a queue-based
// timing model of the arbiter (AW=2, BUSY_CYC=4).
module tb_jt89_wr_arb;

  localparam int unsigned AW    = 2;
  localparam int unsigned BUSY  = 4;
  localparam int          DEPTH = 1 << AW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b1;
  logic       a_wr = 1'b0;
  logic [7:0] a_din = 8'h00;
  logic       b_wr = 1'b0;
  logic [7:0] b_din = 8'h00;
  logic       a_full, b_full, psg_wr_n, busy;
  logic [7:0] psg_din;
`ifdef JT89_ARB_STATS_EN
  logic [7:0] a_drops, b_drops;
`endif

  int checks = 0;
  int errors = 0;

  jt89_wr_arb #(.AW(AW), .BUSY_CYC(BUSY)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .a_wr     (a_wr),
    .a_din    (a_din),
    .a_full   (a_full),
    .b_wr     (b_wr),
    .b_din    (b_din),
    .b_full   (b_full),
    .psg_wr_n (psg_wr_n),
    .psg_din  (psg_din),
    .busy     (busy)
`ifdef JT89_ARB_STATS_EN
    ,
    .a_drops  (a_drops),
    .b_drops  (b_drops)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: byte queues per master, port free/decided/holding timeline
  logic [7:0] mqa[$];
  logic [7:0] mqb[$];
  int         m_grant = -1;
  int         m_ticks = 0;
  int         m_rr = 0;
  int         m_owner = 0;
  bit         m_hold = 0;
  bit         m_lock = 0;
  logic [7:0] mb;
  bit         na, nb;
  int         tick_total = 0;
  logic       exp_wr_n = 1'b1;
  logic [7:0] exp_din = 8'h00;
  logic       exp_busy = 1'b0;
  logic       exp_a_full = 1'b0;
  logic       exp_b_full = 1'b0;
`ifdef JT89_ARB_STATS_EN
  logic [7:0] exp_a_drops = 8'h00;
  logic [7:0] exp_b_drops = 8'h00;
`endif

  always @(posedge clk) begin
    if (clk_en) tick_total++;
    if (rst) begin
      mqa.delete();
      mqb.delete();
      m_grant = -1; m_ticks = 0; m_rr = 0; m_owner = 0; m_hold = 0; m_lock = 0;
      exp_wr_n = 1'b1; exp_din = 8'h00; exp_busy = 1'b0;
      exp_a_full = 1'b0; exp_b_full = 1'b0;
`ifdef JT89_ARB_STATS_EN
      exp_a_drops = 8'h00; exp_b_drops = 8'h00;
`endif
    end else begin
      exp_wr_n = 1'b1;
      if (m_grant >= 0) begin
        if (m_grant == 0) mb = mqa.pop_front();
        else              mb = mqb.pop_front();
        exp_din  = mb;
        exp_wr_n = 1'b0;
        exp_busy = 1'b1;
        m_lock   = mb[7] && !mb[4] && (mb[6:5] != 2'b11);
        m_owner  = m_grant;
        m_rr     = 1 - m_grant;
        m_ticks  = BUSY;
        m_hold   = 1;
        m_grant  = -1;
      end else if (m_hold) begin
        exp_busy = 1'b1;
        if (clk_en) begin
          m_ticks--;
          if (m_ticks == 0) m_hold = 0;
        end
      end else begin
        exp_busy = 1'b0;
        na = (mqa.size() > 0);
        nb = (mqb.size() > 0);
        if (m_lock) begin
          if (m_owner == 0 ? na : nb) m_grant = m_owner;
        end else if (m_rr == 0) begin
          if (na) m_grant = 0; else if (nb) m_grant = 1;
        end else begin
          if (nb) m_grant = 1; else if (na) m_grant = 0;
        end
      end
      if (a_wr) begin
        if (mqa.size() < DEPTH) mqa.push_back(a_din);
`ifdef JT89_ARB_STATS_EN
        else if (exp_a_drops != 8'hFF) exp_a_drops = exp_a_drops + 8'd1;
`endif
      end
      if (b_wr) begin
        if (mqb.size() < DEPTH) mqb.push_back(b_din);
`ifdef JT89_ARB_STATS_EN
        else if (exp_b_drops != 8'hFF) exp_b_drops = exp_b_drops + 8'd1;
`endif
      end
      exp_a_full = (mqa.size() == DEPTH);
      exp_b_full = (mqb.size() == DEPTH);
    end
  end

  // Log of every byte written to the PSG and the clk_en tick count at that moment
  logic [7:0] issued[$];
  int         issue_tick[$];

  always @(negedge clk) begin
    if (!psg_wr_n) begin
      issued.push_back(psg_din);
      issue_tick.push_back(tick_total);
    end
  end

  task automatic push(input logic aw, input logic [7:0] ad, input logic bw, input logic [7:0] bd);
    a_wr = aw; a_din = ad; b_wr = bw; b_din = bd;
    @(negedge clk);
    a_wr = 1'b0; b_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; clk_en = 1'b1; a_wr = 1'b0; b_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1; a_wr = 1'b0; b_wr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (psg_wr_n !== 1'b1) begin errors++; $display("FAIL reset_wr_n: got %b expected 1", psg_wr_n); end
    checks++; if (psg_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %02h expected 00", psg_din); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL reset_a_full: got %b expected 0", a_full); end
    checks++; if (b_full !== 1'b0) begin errors++; $display("FAIL reset_b_full: got %b expected 0", b_full); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    int base;
    int busy_cyc;
    do_reset();
    base = issued.size();
    push(1'b1, 8'h9F, 1'b0, 8'h00);
    checks++; if (psg_wr_n !== 1'b1) begin errors++; $display("FAIL single_lat0: got %b expected 1", psg_wr_n); end
    @(negedge clk);
    checks++; if (psg_wr_n !== 1'b1) begin errors++; $display("FAIL single_lat1: got %b expected 1", psg_wr_n); end
    @(negedge clk);
    checks++; if (psg_wr_n !== 1'b0) begin errors++; $display("FAIL single_lat2: got %b expected 0", psg_wr_n); end
    checks++; if (psg_din !== 8'h9F) begin errors++; $display("FAIL single_din: got %02h expected 9f", psg_din); end
    busy_cyc = busy ? 1 : 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) busy_cyc++;
    end
    checks++; if (busy_cyc != 5) begin errors++; $display("FAIL single_busy_len: got %0d expected 5", busy_cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    checks++; if (issued.size() != base + 1) begin errors++; $display("FAIL single_count: got %0d expected %0d", issued.size() - base, 1); end
  endtask

  task automatic test_round_robin();
    int base;
    int gap;
    logic [7:0] got;
    logic [7:0] exp_ord [4];
    exp_ord = '{8'h90, 8'hB0, 8'h91, 8'hB1};
    do_reset();
    base = issued.size();
    push(1'b1, 8'h90, 1'b1, 8'hB0);
    push(1'b1, 8'h91, 1'b1, 8'hB1);
    repeat (60) @(negedge clk);
    checks++; if (issued.size() != base + 4) begin errors++; $display("FAIL rr_count: got %0d expected 4", issued.size() - base); end
    for (int i = 0; i < 4; i++) begin
      got = (base + i < issued.size()) ? issued[base + i] : 8'h00;
      checks++; if (got !== exp_ord[i]) begin errors++; $display("FAIL rr_order[%0d]: got %02h expected %02h", i, got, exp_ord[i]); end
    end
    for (int i = 1; i < 4; i++) begin
      gap = (base + i < issue_tick.size()) ? issue_tick[base + i] - issue_tick[base + i - 1] : 0;
      checks++; if (gap < BUSY) begin errors++; $display("FAIL rr_gap[%0d]: got %0d ticks expected >= %0d", i, gap, BUSY); end
    end
  endtask

  task automatic test_lock();
    int base;
    logic [7:0] got;
    logic [7:0] exp_ord [3];
    exp_ord = '{8'h8A, 8'h05, 8'hBF};
    do_reset();
    base = issued.size();
    push(1'b1, 8'h8A, 1'b1, 8'hBF);
    repeat (40) @(negedge clk);
    checks++; if (issued.size() != base + 1) begin errors++; $display("FAIL lock_hold_count: got %0d expected 1", issued.size() - base); end
    push(1'b1, 8'h05, 1'b0, 8'h00);
    repeat (40) @(negedge clk);
    checks++; if (issued.size() != base + 3) begin errors++; $display("FAIL lock_count: got %0d expected 3", issued.size() - base); end
    for (int i = 0; i < 3; i++) begin
      got = (base + i < issued.size()) ? issued[base + i] : 8'h00;
      checks++; if (got !== exp_ord[i]) begin errors++; $display("FAIL lock_order[%0d]: got %02h expected %02h", i, got, exp_ord[i]); end
    end
  endtask

  task automatic test_full_drop();
    int base;
    logic [7:0] got;
    logic [7:0] exp_ord [5];
    exp_ord = '{8'h9F, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
    do_reset();
    base = issued.size();
    push(1'b1, 8'h9F, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    clk_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push(1'b0, 8'h00, 1'b1, 8'(8'hC0 + i));
      if (i == 2) begin
        checks++; if (b_full !== 1'b0) begin errors++; $display("FAIL full_after3: got %b expected 0", b_full); end
      end
      if (i >= 3) begin
        checks++; if (b_full !== 1'b1) begin errors++; $display("FAIL full_after%0d: got %b expected 1", i + 1, b_full); end
      end
    end
`ifdef JT89_ARB_STATS_EN
    checks++; if (b_drops !== 8'd2) begin errors++; $display("FAIL b_drops: got %0d expected 2", b_drops); end
    checks++; if (a_drops !== 8'd0) begin errors++; $display("FAIL a_drops: got %0d expected 0", a_drops); end
`endif
    clk_en = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (issued.size() != base + 5) begin errors++; $display("FAIL full_count: got %0d expected 5", issued.size() - base); end
    for (int i = 0; i < 5; i++) begin
      got = (base + i < issued.size()) ? issued[base + i] : 8'h00;
      checks++; if (got !== exp_ord[i]) begin errors++; $display("FAIL full_order[%0d]: got %02h expected %02h", i, got, exp_ord[i]); end
    end
    checks++; if (b_full !== 1'b0) begin errors++; $display("FAIL full_drained: got %b expected 0", b_full); end
  endtask

  task automatic test_noise_volume();
    int base;
    logic [7:0] got;
    logic [7:0] exp_ord [2];
    exp_ord = '{8'hE4, 8'hD0};
    do_reset();
    base = issued.size();
    push(1'b1, 8'hE4, 1'b1, 8'hD0);
    repeat (40) @(negedge clk);
    checks++; if (issued.size() != base + 2) begin errors++; $display("FAIL nolock_count: got %0d expected 2", issued.size() - base); end
    for (int i = 0; i < 2; i++) begin
      got = (base + i < issued.size()) ? issued[base + i] : 8'h00;
      checks++; if (got !== exp_ord[i]) begin errors++; $display("FAIL nolock_order[%0d]: got %02h expected %02h", i, got, exp_ord[i]); end
    end
  endtask

  task automatic test_reset_mid_issue();
    int base;
    bit found;
    do_reset();
    base = issued.size();
    push(1'b1, 8'h9E, 1'b0, 8'h00);
    push(1'b1, 8'h9F, 1'b0, 8'h00);
    push(1'b1, 8'h81, 1'b0, 8'h00);
    push(1'b1, 8'h82, 1'b0, 8'h00);
    push(1'b1, 8'h83, 1'b0, 8'h00);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!busy) found = 1;
      else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_idle_wait: busy stuck at %b expected 0 within 20 cycles", busy); end
    checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL midrst_prefull: got %b expected 1", a_full); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (psg_wr_n !== 1'b1) begin errors++; $display("FAIL midrst_wr_n: got %b expected 1", psg_wr_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL midrst_a_full: got %b expected 0", a_full); end
    checks++; if (issued.size() != base + 1) begin errors++; $display("FAIL midrst_count: got %0d expected 1", issued.size() - base); end
    rst = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (issued.size() != base + 1) begin errors++; $display("FAIL midrst_after: got %0d expected 1", issued.size() - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      a_wr   = ($urandom_range(0, 99) < 35);
      a_din  = 8'($urandom);
      b_wr   = ($urandom_range(0, 99) < 35);
      b_din  = 8'($urandom);
      clk_en = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      checks++; if (psg_wr_n !== exp_wr_n) begin errors++; $display("FAIL rand_wr_n@%0d: got %b expected %b", c, psg_wr_n, exp_wr_n); end
      checks++; if (psg_din !== exp_din) begin errors++; $display("FAIL rand_din@%0d: got %02h expected %02h", c, psg_din, exp_din); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy@%0d: got %b expected %b", c, busy, exp_busy); end
      checks++; if (a_full !== exp_a_full) begin errors++; $display("FAIL rand_a_full@%0d: got %b expected %b", c, a_full, exp_a_full); end
      checks++; if (b_full !== exp_b_full) begin errors++; $display("FAIL rand_b_full@%0d: got %b expected %b", c, b_full, exp_b_full); end
`ifdef JT89_ARB_STATS_EN
      checks++; if (a_drops !== exp_a_drops) begin errors++; $display("FAIL rand_a_drops@%0d: got %0d expected %0d", c, a_drops, exp_a_drops); end
      checks++; if (b_drops !== exp_b_drops) begin errors++; $display("FAIL rand_b_drops@%0d: got %0d expected %0d", c, b_drops, exp_b_drops); end
`endif
    end
    a_wr = 1'b0; b_wr = 1'b0; clk_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_lock();
    test_full_drop();
    test_noise_volume();
    test_reset_mid_issue();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
